// File: rtl/muxn_pipe_if.sv
// Handshake bundle for muxn_pipe: an upstream valid/ready channel carrying the
// flattened data and select, and a downstream valid/ready channel carrying the result.
interface muxn_pipe_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   d;
  logic [SELW-1:0]      s;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     y;
  logic [SELW-1:0]      y_sel;
  logic                 sel_err;

  modport master (
    output in_valid, d, s, out_ready,
    input  in_ready, out_valid, y, y_sel, sel_err
  );

  modport slave (
    input  in_valid, d, s, out_ready,
    output in_ready, out_valid, y, y_sel, sel_err
  );
endinterface

// File: rtl/muxn_pipe.sv
// N-way WIDTH-bit registered selector with valid/ready on both sides.
// A main output register plus one skid entry keeps full rate with a registered in_ready.
module muxn_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic          clk,
  input  logic          reset,
  muxn_pipe_if.slave    bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] select_data(
    input logic [N*WIDTH-1:0] dv,
    input logic [SELW-1:0]    sv
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(sv) == i) r = dv[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  function automatic logic select_err(input logic [SELW-1:0] sv);
    return (int'(sv) >= N);
  endfunction

  state_t            state;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              acc;
  logic              tak;

  logic [WIDTH-1:0]  cap_data_p0;
  logic [SELW-1:0]   cap_sel_p0;
  logic              cap_err_p0;

  logic [WIDTH-1:0]  m_data_p1;
  logic [SELW-1:0]   m_sel_p1;
  logic              m_err_p1;
  logic [WIDTH-1:0]  k_data_p1;
  logic [SELW-1:0]   k_sel_p1;
  logic              k_err_p1;

  assign acc = bus.in_valid && in_ready_r;
  assign tak = out_valid_r && bus.out_ready;

  // Stage p0: select decode on the incoming beat
  always_comb begin
    cap_data_p0 = select_data(bus.d, bus.s);
    cap_sel_p0  = bus.s;
    cap_err_p0  = select_err(bus.s);
  end

  // Stage p1: main register M and skid register K, sequenced by the handshake FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      m_data_p1   <= '0;
      m_sel_p1    <= '0;
      m_err_p1    <= 1'b0;
      k_data_p1   <= '0;
      k_sel_p1    <= '0;
      k_err_p1    <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          in_ready_r <= 1'b1;
          if (acc) begin
            m_data_p1   <= cap_data_p0;
            m_sel_p1    <= cap_sel_p0;
            m_err_p1    <= cap_err_p0;
            out_valid_r <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (acc && !tak) begin
            // Consumer stalled: park the new beat so M stays stable
            k_data_p1  <= cap_data_p0;
            k_sel_p1   <= cap_sel_p0;
            k_err_p1   <= cap_err_p0;
            in_ready_r <= 1'b0;
            state      <= TWO;
          end else if (acc && tak) begin
            m_data_p1 <= cap_data_p0;
            m_sel_p1  <= cap_sel_p0;
            m_err_p1  <= cap_err_p0;
          end else if (tak) begin
            out_valid_r <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          if (tak) begin
            m_data_p1  <= k_data_p1;
            m_sel_p1   <= k_sel_p1;
            m_err_p1   <= k_err_p1;
            in_ready_r <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          state       <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.y         = m_data_p1;
  assign bus.y_sel     = m_sel_p1;
  assign bus.sel_err   = m_err_p1;

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed and random-stall bench for muxn_pipe: a 4-way and a 3-way instance
// driven from one initial block, with expected values built by the bench.
module tb_muxn_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  muxn_pipe_if #(.WIDTH(8), .N(4), .SELW(2)) ifa ();
  muxn_pipe_if #(.WIDTH(8), .N(3), .SELW(2)) ifb ();

  muxn_pipe #(.WIDTH(8), .N(4), .SELW(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  muxn_pipe #(.WIDTH(8), .N(3), .SELW(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] q_exp[$];
  logic [31:0] stream_exp[4];
  logic [31:0] hold_word;
  logic        prev_hold;
  logic [31:0] exp_word;
  logic [31:0] obs_word;
  logic [1:0]  rs;
  logic [31:0] rd;
  int          guard;

  initial begin
    stream_exp[0] = 32'h11;
    stream_exp[1] = 32'h22;
    stream_exp[2] = 32'h33;
    stream_exp[3] = 32'h44;

    // Reset held for two cycles with in_valid asserted
    ifa.in_valid = 1'b1; ifa.s = 2'd1; ifa.d = 32'h44332211; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b1; ifb.s = 2'd0; ifb.d = 24'h332211;   ifb.out_ready = 1'b1;
    reset = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_y", 32'(ifa.y), 32'd0);
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("rst_b_out_valid", 32'(ifb.out_valid), 32'd0);
    reset = 1'b0;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    step();
    chk("rel_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("rel_out_valid", 32'(ifa.out_valid), 32'd0);

    // Streaming s = 0..3 back-to-back
    ifa.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifa.s = 2'(i);
      step();
      chk($sformatf("stream_vld%0d", i), 32'(ifa.out_valid), 32'd1);
      chk($sformatf("stream_y%0d", i), 32'(ifa.y), stream_exp[i]);
      chk($sformatf("stream_sel%0d", i), 32'(ifa.y_sel), 32'(i));
      chk($sformatf("stream_err%0d", i), 32'(ifa.sel_err), 32'd0);
    end
    ifa.in_valid = 1'b0;
    step();
    chk("stream_drain", 32'(ifa.out_valid), 32'd0);

    // Backpressure into the skid entry
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.s = 2'd1;
    step();
    chk("bp_y_first", 32'(ifa.y), 32'h22);
    chk("bp_ready_one", 32'(ifa.in_ready), 32'd1);
    ifa.s = 2'd2;
    step();
    chk("bp_ready_two", 32'(ifa.in_ready), 32'd0);
    chk("bp_y_hold", 32'(ifa.y), 32'h22);
    ifa.in_valid = 1'b0;
    step();
    chk("bp_y_hold2", 32'(ifa.y), 32'h22);
    chk("bp_vld_hold", 32'(ifa.out_valid), 32'd1);
    ifa.out_ready = 1'b1;
    step();
    chk("bp_y_second", 32'(ifa.y), 32'h33);
    chk("bp_ready_back", 32'(ifa.in_ready), 32'd1);
    chk("bp_vld_second", 32'(ifa.out_valid), 32'd1);
    step();
    chk("bp_empty", 32'(ifa.out_valid), 32'd0);

    // Out-of-range select on the 3-way instance
    ifb.in_valid = 1'b1; ifb.s = 2'd3;
    step();
    chk("oor_y", 32'(ifb.y), 32'd0);
    chk("oor_err", 32'(ifb.sel_err), 32'd1);
    chk("oor_sel", 32'(ifb.y_sel), 32'd3);
    ifb.s = 2'd2;
    step();
    chk("inr_y", 32'(ifb.y), 32'h33);
    chk("inr_err", 32'(ifb.sel_err), 32'd0);
    chk("inr_sel", 32'(ifb.y_sel), 32'd2);
    ifb.in_valid = 1'b0;
    step();
    chk("oor_drain", 32'(ifb.out_valid), 32'd0);

    // Random stall against a FIFO scoreboard
    prev_hold = 1'b0;
    hold_word = '0;
    for (int c = 0; c < 1000; c++) begin
      obs_word = {21'd0, ifa.sel_err, ifa.y_sel, ifa.y};
      if (prev_hold) begin
        chk("stall_vld_stable", 32'(ifa.out_valid), 32'd1);
        chk("stall_y_stable", obs_word, hold_word);
      end
      rs = 2'($urandom_range(0, 3));
      rd = $urandom();
      ifa.in_valid  = 1'($urandom_range(0, 1));
      ifa.out_ready = ($urandom_range(0, 2) != 0);
      ifa.s = rs;
      ifa.d = rd;
      if (ifa.out_valid && ifa.out_ready) begin
        if (q_exp.size() == 0) begin
          chk("rand_unexpected_out", obs_word, 32'hFFFF_FFFF);
        end else begin
          exp_word = q_exp.pop_front();
          chk("rand_out", obs_word, exp_word);
        end
      end
      if (ifa.in_valid && ifa.in_ready)
        q_exp.push_back({22'd0, rs, 8'((rd >> (8 * int'(rs))) & 32'hFF)});
      prev_hold = ifa.out_valid && !ifa.out_ready;
      hold_word = obs_word;
      step();
    end
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    guard = 0;
    while (q_exp.size() != 0 && guard < 10) begin
      if (ifa.out_valid) begin
        exp_word = q_exp.pop_front();
        chk("drain_out", {21'd0, ifa.sel_err, ifa.y_sel, ifa.y}, exp_word);
      end
      step();
      guard++;
    end
    chk("drain_left", 32'(q_exp.size()), 32'd0);
    chk("drain_empty", 32'(ifa.out_valid), 32'd0);

    // Reset while holding two entries
    ifa.d = 32'h44332211;
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.s = 2'd0;
    step();
    ifa.s = 2'd1;
    step();
    chk("two_ready", 32'(ifa.in_ready), 32'd0);
    ifa.in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst2_in_ready", 32'(ifa.in_ready), 32'd0);
    step();
    chk("rst2_ready_back", 32'(ifa.in_ready), 32'd1);
    chk("rst2_no_stale", 32'(ifa.out_valid), 32'd0);
    ifa.in_valid = 1'b1; ifa.s = 2'd2; ifa.out_ready = 1'b1;
    step();
    chk("rst2_first_y", 32'(ifa.y), 32'h33);
    chk("rst2_first_sel", 32'(ifa.y_sel), 32'd2);
    ifa.in_valid = 1'b0;
    step();
    chk("rst2_drain", 32'(ifa.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered output and a valid/ready handshake on both sides. It succeeds the plain 2-input combinational mux.
- Used between datapath stages (e.g. forwarding or write-back source select), where the select and data arrive with a valid and the consumer may stall.
- Contains a 2-entry skid buffer, so it sustains one transfer per cycle with registered in_ready. It also flags out-of-range selects.

Parameters:
- WIDTH, 8, data width of each input channel and of y.
- N, 4, number of input channels (2..16).
- SELW, 2, select width; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents d and s this cycle.
- in_ready  output  1  block can accept a transfer this cycle.
- d  input  N*WIDTH  flattened channels; channel i occupies bits [i*WIDTH +: WIDTH].
- s  input  SELW  channel select, sampled with in_valid.
- out_valid  output  1  y, y_sel and sel_err are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- y  output  WIDTH  selected channel data (registered).
- y_sel  output  SELW  select value that produced y (registered).
- sel_err  output  1  the select for this output was >= N (registered).

Behaviour:
- Clocking and reset: one clock domain. reset is synchronous and active-high. All outputs come from flops; there is no combinational path from in_* to out_* or from out_ready to in_ready.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Once out_valid is asserted, y, y_sel and sel_err stay stable until the output transfer completes.
- Select function:
  - For s < N, captured data = d[s*WIDTH +: WIDTH] and err = 0.
  - For s >= N, captured data = all zeros and err = 1.
  - The captured select value is always s itself.
- Storage: main register M drives the outputs; skid register K holds one overflow entry.
- States (2-bit):
  - EMPTY: out_valid = 0, in_ready = 1.
  - ONE: M full, K empty, out_valid = 1, in_ready = 1.
  - TWO: M and K full, out_valid = 1, in_ready = 0.
- Transitions, where acc = input transfer and tak = output transfer:
  - EMPTY: acc -> load M, go to ONE; otherwise stay.
  - ONE:
    - acc && !tak -> load K, go to TWO.
    - acc && tak -> load M, stay in ONE.
    - !acc && tak -> go to EMPTY.
    - otherwise stay.
  - TWO: tak -> move K to M, go to ONE (no acc possible, since in_ready = 0); otherwise stay.
- Latency and throughput:
  - Latency is 1 cycle: an entry accepted at edge n is visible on y after edge n; out_valid is first sampled high at edge n+1.
  - Throughput is 1 transfer per cycle whenever out_ready is held high.
- Ordering: strict FIFO. No entry is dropped or duplicated.
- Reset values:
  - out_valid = 0, y = 0, y_sel = 0, sel_err = 0, state = EMPTY.
  - K contents are cleared to 0.
  - in_ready = 0 while reset is high, and 1 in the first cycle after release.
- Reset mid-operation: any buffered entries are discarded. Inputs during the reset cycle are ignored even if in_valid = 1.
- Boundary conditions:
  - in_valid low: d and s are don't-care and must not alter state.
  - out_ready high with out_valid low: no effect.
  - Simultaneous acc and tak in ONE keeps full rate with no bubble.
  - Select s = N-1 is legal; s = N through 2**SELW-1 set sel_err.

Test Plan:
- Reset: hold reset 2 cycles with in_valid = 1 -> out_valid = 0, y = 0, in_ready = 0 during reset; in_ready = 1 one cycle after release; nothing is emitted.
- Streaming (WIDTH = 8, N = 4, out_ready = 1): d = {8'h44, 8'h33, 8'h22, 8'h11}, s = 0,1,2,3 on consecutive cycles -> y = 11, 22, 33, 44 one cycle later, back-to-back, with y_sel = 0..3.
- Backpressure:
  - out_ready = 0 while sending s = 1 then s = 2 -> state TWO, in_ready = 0, y holds 8'h22.
  - Raise out_ready -> y = 22 then 33, in_ready back to 1 after the first output transfer, no loss.
- Out-of-range select (N = 3, SELW = 2): s = 3 -> y = 0, sel_err = 1, y_sel = 3; a following s = 2 -> sel_err = 0.
- Random stall: 1000 random in_valid/out_ready patterns -> output sequence equals the scoreboard model; out_valid and y never change while out_valid && !out_ready.
- Reset in state TWO -> next cycle out_valid = 0, state EMPTY; the first post-reset input is the next output.
